// File: rtl/serial_full_adder_ctrl.sv
// Bit-serial WIDTH-bit adder built around a single full-adder slice, LSB first.
// Start/busy/done handshake; result and final carry are held until the next one is published.
module serial_full_adder_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             sys_clk,
    input  logic             sys_rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             slice_a,
    output logic             slice_b,
    output logic             slice_c
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] s_sh;
    logic [WIDTH-1:0] s_shifted;
    logic             c;
    logic             s_bit;
    logic             c_nxt;
    logic [CW-1:0]    cnt;
    logic             last_bit;

    // The single full-adder slice.
    assign slice_a   = a_sh[0];
    assign slice_b   = b_sh[0];
    assign slice_c   = c;
    assign s_bit     = a_sh[0] ^ b_sh[0] ^ c;
    assign c_nxt     = (a_sh[0] & b_sh[0]) | (a_sh[0] & c) | (b_sh[0] & c);
    assign s_shifted = {s_bit, s_sh[WIDTH-1:1]};
    assign last_bit  = (cnt == LAST);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // NOTE: every output of this block gets a default first, so no path can
    // leave a signal unassigned and infer a latch.
    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: if (start) state_nxt = RUN;
            RUN: begin
                busy = 1'b1;
                if (last_bit) state_nxt = DONE;
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            a_sh <= '0;
            b_sh <= '0;
            s_sh <= '0;
            c    <= 1'b0;
            cnt  <= '0;
            sum  <= '0;
            cout <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        a_sh <= a_in;
                        b_sh <= b_in;
                        c    <= cin;
                        cnt  <= '0;
                    end
                end
                RUN: begin
                    a_sh <= a_sh >> 1;
                    b_sh <= b_sh >> 1;
                    c    <= c_nxt;
                    s_sh <= s_shifted;
                    cnt  <= cnt + 1'b1;
                    // Publish on the edge that leaves RUN; sum/cout hold otherwise.
                    if (last_bit) begin
                        sum  <= s_shifted;
                        cout <= c_nxt;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/serial_full_adder_ctrl.md
Name: serial_full_adder_ctrl

Overview:
Bit-serial multi-bit adder built around a single full-adder slice (sum = a^b^cin, carry = majority). It loads two WIDTH-bit operands on a start pulse, feeds one bit pair per clock (LSB first) plus a registered carry through the slice, and assembles the WIDTH-bit sum and final carry. It sits directly upstream of the 1-bit full adder and turns it into a multi-cycle word adder with a start/busy/done handshake.

Parameters:
WIDTH, 8, operand/sum width in bits; legal range 2..32

Ports:
sys_clk  input  1  system clock, all logic on rising edge
sys_rst_n  input  1  synchronous active-low reset
start  input  1  request pulse; sampled only in IDLE
a_in  input  WIDTH  operand A, captured on accepted start
b_in  input  WIDTH  operand B, captured on accepted start
cin  input  1  initial carry-in, captured on accepted start
busy  output  1  high while bits are being processed (RUN)
done  output  1  one-cycle pulse when result becomes valid
sum  output  WIDTH  registered result; holds until the next result is published
cout  output  1  registered final carry; holds with sum
slice_a  output  1  current A bit presented to the slice (debug/observe)
slice_b  output  1  current B bit presented to the slice
slice_c  output  1  current registered carry presented to the slice

Behaviour:
- Reset (sys_rst_n=0 at a rising edge): state=IDLE; busy=0, done=0, sum=0, cout=0; operand shift regs, carry reg, bit counter, and sum shift reg all cleared. Applies from any state; an aborted addition publishes nothing.
- States: IDLE, RUN, DONE.
- IDLE: start=1 at edge T loads a_in/b_in into shift regs, cin into carry reg, counter=0, and enters RUN at T (busy=1 visible after edge T). start=0: stay.
- RUN: each edge computes s = a_sh[0]^b_sh[0]^c and c' = majority(a_sh[0],b_sh[0],c); shifts s into the MSB of the sum shift reg (right shift); shifts a_sh and b_sh right by one; c<=c'; counter+1. After exactly WIDTH RUN edges (counter reaches WIDTH-1 on its last processed edge) → DONE. On that same transition edge, sum<=completed shift reg and cout<=final c'.
- DONE: done=1, busy=0 for exactly one cycle; unconditional return to IDLE on the next edge; done=0 in IDLE.
- Latency: start accepted at edge T → done high for the cycle after edge T+WIDTH → next start accepted no earlier than edge T+WIDTH+2.
- start during RUN or DONE: ignored, no queueing; operands and result are unaffected.
- a_in/b_in/cin matter only at the accepting edge; later changes have no effect.
- slice_a/slice_b/slice_c = a_sh[0], b_sh[0], c (combinational from registers); their values are don't-care outside RUN.
- Arithmetic is modulo 2^WIDTH: {cout,sum} = a_in + b_in + cin exactly (WIDTH+1 bits).
- Counter width: $clog2(WIDTH) bits minimum; no wrap occurs inside RUN.
- sum/cout change only on the edge entering DONE or on reset.

Test Plan:
- WIDTH=8: a=3, b=5, cin=0, start 1 cycle → busy high for 8 cycles, done pulses once, sum=8, cout=0, total 9 cycles start-to-done.
- a=255, b=1, cin=0 → sum=0, cout=1; a=255, b=255, cin=1 → sum=255, cout=1; a=0, b=0, cin=1 → sum=1, cout=0.
- start held high continuously with operands changing every cycle → only values at the accepting edges are used; results appear back-to-back with one IDLE cycle between done pulses; sum is unchanged during RUN.
- Reset asserted in the 4th RUN cycle of a=100, b=27 → next cycle busy=0, done=0, sum=0, cout=0; no done pulse follows. Then a=100, b=27 → sum=127, cout=0.
- Random self-check: 1000 random a/b/cin vectors compared against {cout,sum}=a+b+cin. In RUN, each cycle slice_a/slice_b must equal bit k of the captured operands for k=0..7.
